// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps the program counter, issues one instruction
// memory request at a time, holds the fetched word for the datapath, and
// steers the next fetch on jr / jump / branch redirects or an external flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int DATA_W = 32;

  // FETCH: request outstanding; FULL: holding an instruction for the datapath;
  // DROP: the outstanding request belongs to a flushed path and is discarded.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DROP  = 2'd2
  } stateT;

  stateT             state;
  logic [DATA_W-1:0] pc;        // next address to fetch (already PC+4 while FULL)
  logic [DATA_W-1:0] nextPc;    // pc after the held instruction is consumed
  logic [DATA_W-1:0] flushTgt;

  // Word-align an address by clearing the byte offset.
  function automatic logic [DATA_W-1:0] alignWord(input logic [DATA_W-1:0] a);
    return {a[DATA_W-1:2], 2'b00};
  endfunction

  // J/JAL target: region bits of the sequential PC with the 26-bit index.
  function automatic logic [DATA_W-1:0] jumpTarget(input logic [DATA_W-1:0] seqPc,
                                                   input logic [25:0]       idx);
    return {seqPc[DATA_W-1:28], idx, 2'b00};
  endfunction

  // Branch target: sequential PC plus word-scaled signed offset, wrapping mod 2^32.
  function automatic logic [DATA_W-1:0] branchTarget(input logic [DATA_W-1:0]        seqPc,
                                                     input logic signed [DATA_W-1:0] off);
    logic signed [DATA_W-1:0] offWords;
    offWords = off <<< 2;
    return seqPc + $unsigned(offWords);
  endfunction

  assign pc_4     = instr_pc + 32'd4;
  assign flushTgt = alignWord(flush_pc);

  // Redirect selection; inputs only matter when the held instruction is consumed.
  always_comb begin
    nextPc = pc;
    if (instr_valid && instr_ready) begin
      if (jr)                nextPc = alignWord(jr_target);
      else if (jump)         nextPc = jumpTarget(pc_4, jump_index);
      else if (branch_taken) nextPc = branchTarget(pc_4, $signed(branch_offset));
    end
  end

  // Fetch state machine with registered request, address and instruction outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b1;
      imem_addr   <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (flush) begin
            pc          <= flushTgt;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            if (imem_ack) begin
              // Returning word belongs to the old path; start the new one now.
              state     <= FETCH;
              imem_addr <= flushTgt;
            end else begin
              // Keep presenting the old address until its ack arrives.
              state     <= DROP;
            end
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc + 32'd4;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= FULL;
          end
        end
        FULL: begin
          if (flush) begin
            pc          <= flushTgt;
            imem_addr   <= flushTgt;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (instr_ready) begin
            pc          <= nextPc;
            imem_addr   <= nextPc;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        DROP: begin
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
          if (flush) begin
            pc <= flushTgt;
            if (imem_ack) begin
              imem_addr <= flushTgt;
              state     <= FETCH;
            end
          end else if (imem_ack) begin
            imem_addr <= pc;
            state     <= FETCH;
          end
        end
        default: begin
          imem_req    <= 1'b1;
          imem_addr   <= pc;
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an instruction-memory responder pushes every returned
// word with its address onto a scoreboard; scenario tasks pop and compare when
// the unit presents the instruction.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_4;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        flush;
  logic [31:0] flush_pc;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetchT;

  fetchT       sb[$];
  int          nAssert;
  int          nFail;
  int          cyc;
  bit          autoAck;
  logic        manAck;
  logic [31:0] manData;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .pc_4(pc_4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: in auto mode acks every request in its first cycle.
  initial begin
    fetchT ent;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (autoAck) begin
        imem_ack = 1'b0;
        if (imem_req === 1'b1) begin
          imem_ack   = 1'b1;
          imem_rdata = memWord(imem_addr);
          ent.addr   = imem_addr;
          ent.data   = imem_rdata;
          sb.push_back(ent);
        end
      end else begin
        imem_ack   = manAck;
        imem_rdata = manData;
      end
    end
  end

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Present one consume cycle with the given redirect / flush inputs.
  task automatic consume(input logic bt, input logic [31:0] off,
                         input logic jmp, input logic [25:0] idx,
                         input logic jrr, input logic [31:0] jt,
                         input logic fl, input logic [31:0] fpc);
    @(posedge clk); #1;
    instr_ready = 1'b1; branch_taken = bt; branch_offset = off;
    jump = jmp; jump_index = idx; jr = jrr; jr_target = jt;
    flush = fl; flush_pc = fpc;
    @(posedge clk); #1;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;
    flush = 1'b0; flush_pc = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nAssert++; if (instr_valid !== 1'b0) begin nFail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    nAssert++; if (instr !== 32'h0) begin nFail++; $display("FAIL rst_instr: got %h want 0", instr); end
    nAssert++; if (instr_pc !== 32'h0) begin nFail++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    nAssert++; if (imem_addr !== 32'h0) begin nFail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    reset = 1'b0;
    @(negedge clk);
    nAssert++; if (imem_req !== 1'b1) begin nFail++; $display("FAIL rst_req: got %b want 1", imem_req); end
    nAssert++; if (imem_addr !== 32'h0) begin nFail++; $display("FAIL rst_first_addr: got %h want 0", imem_addr); end
    nAssert++; if (instr_valid !== 1'b0) begin nFail++; $display("FAIL rst_valid_after: got %b want 0", instr_valid); end
  endtask

  task automatic test_sequential();
    bit    ok;
    fetchT e;
    int    prevCyc;
    prevCyc     = 0;
    autoAck     = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitValid(ok);
      nAssert++;
      if (!ok || sb.size() == 0) begin
        nFail++; $display("FAIL seq_valid%0d: got timeout/empty want instruction", i);
      end else begin
        e = sb.pop_front();
        nAssert++; if (e.addr !== 32'(i * 4)) begin nFail++; $display("FAIL seq_addr%0d: got %h want %h", i, e.addr, 32'(i * 4)); end
        nAssert++; if (instr_pc !== 32'(i * 4)) begin nFail++; $display("FAIL seq_pc%0d: got %h want %h", i, instr_pc, 32'(i * 4)); end
        nAssert++; if (instr !== e.data) begin nFail++; $display("FAIL seq_instr%0d: got %h want %h", i, instr, e.data); end
        nAssert++; if (pc_4 !== 32'(i * 4 + 4)) begin nFail++; $display("FAIL seq_pc4_%0d: got %h want %h", i, pc_4, 32'(i * 4 + 4)); end
        if (i > 0) begin
          nAssert++; if (cyc - prevCyc != 2) begin nFail++; $display("FAIL seq_rate%0d: got %0d cycles want 2", i, cyc - prevCyc); end
        end
        prevCyc = cyc;
      end
    end
    @(posedge clk); #1;
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit    ok;
    fetchT e;
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin
      nFail++; $display("FAIL stall_valid: got timeout/empty want instruction");
    end else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'hC) begin nFail++; $display("FAIL stall_pc: got %h want %h", instr_pc, 32'hC); end
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        nAssert++; if (instr !== e.data) begin nFail++; $display("FAIL stall_instr%0d: got %h want %h", k, instr, e.data); end
        nAssert++; if (instr_pc !== 32'hC) begin nFail++; $display("FAIL stall_hold_pc%0d: got %h want %h", k, instr_pc, 32'hC); end
        nAssert++; if (imem_req !== 1'b0) begin nFail++; $display("FAIL stall_req%0d: got %b want 0", k, imem_req); end
        nAssert++; if (instr_valid !== 1'b1) begin nFail++; $display("FAIL stall_valid%0d: got %b want 1", k, instr_valid); end
      end
      consume(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      nAssert++; if (imem_addr !== 32'h10) begin nFail++; $display("FAIL stall_next_addr: got %h want %h", imem_addr, 32'h10); end
    end
  endtask

  task automatic test_branch();
    bit    ok;
    fetchT e;
    waitValid(ok);
    nAssert++; if (!ok || sb.size() == 0) begin nFail++; $display("FAIL br_pre: got timeout/empty want instruction"); end
    else e = sb.pop_front();
    consume(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h100);
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin nFail++; $display("FAIL br_at100: got timeout/empty want instruction"); end
    else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'h100) begin nFail++; $display("FAIL br_pc: got %h want %h", instr_pc, 32'h100); end
      nAssert++; if (pc_4 !== 32'h104) begin nFail++; $display("FAIL br_pc4: got %h want %h", pc_4, 32'h104); end
    end
    consume(1'b1, 32'hFFFF_FFFE, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    nAssert++; if (imem_addr !== 32'hFC) begin nFail++; $display("FAIL br_target: got %h want %h", imem_addr, 32'hFC); end
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin nFail++; $display("FAIL br_land: got timeout/empty want instruction"); end
    else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'hFC) begin nFail++; $display("FAIL br_land_pc: got %h want %h", instr_pc, 32'hFC); end
      nAssert++; if (instr !== e.data) begin nFail++; $display("FAIL br_land_instr: got %h want %h", instr, e.data); end
    end
    consume(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h100);
    waitValid(ok);
    nAssert++; if (!ok || sb.size() == 0) begin nFail++; $display("FAIL jmp_pre: got timeout/empty want instruction"); end
    else e = sb.pop_front();
    consume(1'b1, 32'hFFFF_FFFE, 1'b1, 26'h40, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    nAssert++; if (imem_addr !== 32'h100) begin nFail++; $display("FAIL jmp_over_br: got %h want %h", imem_addr, 32'h100); end
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin nFail++; $display("FAIL jmp_land: got timeout/empty want instruction"); end
    else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'h100) begin nFail++; $display("FAIL jmp_land_pc: got %h want %h", instr_pc, 32'h100); end
    end
  endtask

  task automatic test_jr();
    bit    ok;
    fetchT e;
    consume(1'b1, 32'h8, 1'b1, 26'h40, 1'b1, 32'h2003, 1'b0, '0);
    @(negedge clk);
    nAssert++; if (imem_addr !== 32'h2000) begin nFail++; $display("FAIL jr_target: got %h want %h", imem_addr, 32'h2000); end
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin nFail++; $display("FAIL jr_land: got timeout/empty want instruction"); end
    else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'h2000) begin nFail++; $display("FAIL jr_land_pc: got %h want %h", instr_pc, 32'h2000); end
    end
  endtask

  task automatic test_flush_priority();
    bit    ok;
    fetchT e;
    consume(1'b1, 32'h10, 1'b1, 26'h5, 1'b1, 32'h3000, 1'b1, 32'h203);
    @(negedge clk);
    nAssert++; if (imem_addr !== 32'h200) begin nFail++; $display("FAIL flush_prio: got %h want %h", imem_addr, 32'h200); end
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin nFail++; $display("FAIL flush_prio_land: got timeout/empty want instruction"); end
    else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'h200) begin nFail++; $display("FAIL flush_prio_pc: got %h want %h", instr_pc, 32'h200); end
    end
  endtask

  task automatic test_flush_drop();
    bit    ok;
    fetchT e;
    autoAck = 1'b0;
    manAck  = 1'b0;
    manData = '0;
    @(posedge clk); #1;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    flush       = 1'b1;
    flush_pc    = 32'h80;
    @(posedge clk); #1;
    flush    = 1'b0;
    flush_pc = '0;
    @(negedge clk);
    nAssert++; if (imem_req !== 1'b1) begin nFail++; $display("FAIL drop_req: got %b want 1", imem_req); end
    nAssert++; if (imem_addr !== 32'h204) begin nFail++; $display("FAIL drop_old_addr: got %h want %h", imem_addr, 32'h204); end
    nAssert++; if (instr_valid !== 1'b0) begin nFail++; $display("FAIL drop_valid: got %b want 0", instr_valid); end
    @(negedge clk);
    manAck  = 1'b1;
    manData = 32'hDEAD_BEEF;
    @(negedge clk);
    manAck = 1'b0;
    nAssert++; if (instr_valid !== 1'b0) begin nFail++; $display("FAIL drop_ack_valid: got %b want 0", instr_valid); end
    @(negedge clk);
    nAssert++; if (instr_valid !== 1'b0) begin nFail++; $display("FAIL drop_discard: got %b want 0", instr_valid); end
    nAssert++; if (instr === 32'hDEAD_BEEF) begin nFail++; $display("FAIL drop_word: got %h want old word", instr); end
    nAssert++; if (imem_addr !== 32'h80) begin nFail++; $display("FAIL drop_new_addr: got %h want %h", imem_addr, 32'h80); end
    nAssert++; if (imem_req !== 1'b1) begin nFail++; $display("FAIL drop_new_req: got %b want 1", imem_req); end
    autoAck = 1'b1;
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin nFail++; $display("FAIL drop_land: got timeout/empty want instruction"); end
    else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'h80) begin nFail++; $display("FAIL drop_land_pc: got %h want %h", instr_pc, 32'h80); end
      nAssert++; if (instr !== e.data) begin nFail++; $display("FAIL drop_land_instr: got %h want %h", instr, e.data); end
    end
  endtask

  task automatic test_wrap();
    bit    ok;
    fetchT e;
    consume(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin nFail++; $display("FAIL wrap_top: got timeout/empty want instruction"); end
    else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'hFFFF_FFFC) begin nFail++; $display("FAIL wrap_pc: got %h want %h", instr_pc, 32'hFFFF_FFFC); end
      nAssert++; if (pc_4 !== 32'h0) begin nFail++; $display("FAIL wrap_pc4: got %h want 0", pc_4); end
    end
    consume(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    nAssert++; if (imem_addr !== 32'h0) begin nFail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    waitValid(ok);
    nAssert++;
    if (!ok || sb.size() == 0) begin nFail++; $display("FAIL wrap_land: got timeout/empty want instruction"); end
    else begin
      e = sb.pop_front();
      nAssert++; if (instr_pc !== 32'h0) begin nFail++; $display("FAIL wrap_land_pc: got %h want 0", instr_pc); end
    end
  endtask

  task automatic test_async_reset();
    autoAck = 1'b0;
    manAck  = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    nAssert++; if (instr_valid !== 1'b0) begin nFail++; $display("FAIL areset_valid: got %b want 0", instr_valid); end
    nAssert++; if (instr !== 32'h0) begin nFail++; $display("FAIL areset_instr: got %h want 0", instr); end
    nAssert++; if (imem_addr !== 32'h0) begin nFail++; $display("FAIL areset_addr: got %h want 0", imem_addr); end
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    nAssert++; if (imem_req !== 1'b1) begin nFail++; $display("FAIL areset_req: got %b want 1", imem_req); end
  endtask

  initial begin
    nAssert = 0; nFail = 0; cyc = 0;
    autoAck = 1'b0; manAck = 1'b0; manData = '0;
    reset = 1'b1;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;
    flush = 1'b0; flush_pc = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jr();
    test_flush_priority();
    test_flush_drop();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  fetch address; equals internal PC.
REQ-006 SHALL have port imem_ack  input  1  one-cycle pulse, imem_rdata valid in that cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port instr  output  32  registered instruction to the datapath.
REQ-009 SHALL have port instr_pc  output  32  address of instr.
REQ-010 SHALL have port pc_4  output  32  instr_pc + 4.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_pc are valid.
REQ-012 SHALL have port instr_ready  input  1  datapath consumes instr this cycle.
REQ-013 SHALL have port branch_taken  input  1  conditional branch of consumed instr is taken.
REQ-014 SHALL have port branch_offset  input  32  sign-extended 16-bit immediate.
REQ-015 SHALL have port jump  input  1  J/JAL of consumed instr.
REQ-016 SHALL have port jump_index  input  26  instruction bits [25:0].
REQ-017 SHALL have port jr  input  1  JR of consumed instr.
REQ-018 SHALL have port jr_target  input  32  register-file read data for JR.
REQ-019 SHALL have port flush  input  1  unconditional redirect (exception/restart).
REQ-020 SHALL have port flush_pc  input  32  flush target.

Function
REQ-021 SHALL implement states FETCH, FULL, DROP; one fetch outstanding at most.
REQ-022 In FETCH: imem_req=1, imem_addr=PC held stable until imem_ack.
REQ-023 FETCH with imem_ack: instr<=imem_rdata, instr_pc<=PC, PC<=PC+4, instr_valid<=1, go FULL; instr_valid rises the cycle after ack.
REQ-024 In FULL: imem_req=0; instr, instr_pc, instr_valid held while instr_ready=0.
REQ-025 FULL with instr_ready=1: instr_valid<=0, go FETCH; PC<=redirect target if any redirect, else unchanged (already PC+4).
REQ-026 Redirect inputs (branch_taken, jump, jr) SHALL be sampled only when instr_valid=1 and instr_ready=1; ignored otherwise.
REQ-027 Redirect priority: jr > jump > branch_taken.
REQ-028 jr target = jr_target with bits [1:0] forced to 0.
REQ-029 jump target = {pc_4[31:28], jump_index, 2'b00}.
REQ-030 branch target = pc_4 + (branch_offset << 2), modulo 2^32 (wrap, no overflow flag).
REQ-031 PC+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-032 flush has priority over everything; PC<=flush_pc with [1:0] forced 0; instr_valid<=0.
REQ-033 flush in FETCH without imem_ack same cycle: go DROP; imem_req stays 1 with old address until ack.
REQ-034 flush in FETCH with imem_ack same cycle, or in FULL or DROP: go FETCH (from DROP: go DROP if no ack, keep new PC).
REQ-035 In DROP: imem_ack discards imem_rdata, instr_valid stays 0, next state FETCH with imem_addr=flushed PC.

Reset
REQ-036 reset asserted SHALL immediately force state FETCH, PC=RESET_PC, instr=0, instr_pc=0, instr_valid=0; imem_req=1 from the first clock after deassertion.
REQ-037 reset mid-fetch SHALL abandon the outstanding request; a late imem_ack after reset is not expected by contract.

Verification
REQ-038 Reset, ack 1 cycle after each req, instr_ready=1 -> imem_addr sequence 0,4,8; instr_pc matches; one instr per 2 cycles.
REQ-039 instr_valid=1, instr_ready=0 for 5 cycles -> instr/instr_pc stable, imem_req=0 throughout.
REQ-040 instr_pc=0x100, branch_taken=1, branch_offset=0xFFFFFFFE, consumed -> next imem_addr=0xFC; with jump=1 too, jump_index=0x40 -> 0x100.
REQ-041 jr=1, jump=1, branch_taken=1, jr_target=0x2003 -> next imem_addr=0x2000.
REQ-042 flush (flush_pc=0x80) during FETCH, ack 3 cycles later with 0xDEADBEEF -> word discarded, instr_valid 0, next req at 0x80.
REQ-043 PC=0xFFFFFFFC fetched and consumed with no redirect -> next imem_addr=0x0.
